// File: rtl/dac_frame_sched.sv
// Frame scheduler for the shared X/Y vector DAC: latches requesters at each frame tick,
// hands them the DAC one shape at a time in round-robin order and parks the beam when done.
module dac_frame_sched #(
  parameter int N_REQ         = 4,
  parameter int DAC_WIDTH     = 8,
  parameter int FRAME_CYCLES  = 80000,
  parameter int SETTLE_CYCLES = 4,
  parameter int PARK_X        = 128,
  parameter int PARK_Y        = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DAC_WIDTH-1:0] pt_x,
  input  logic [N_REQ*DAC_WIDTH-1:0] pt_y,
  input  logic [N_REQ-1:0]           pt_valid,
  input  logic [N_REQ-1:0]           pt_last,
  output logic [N_REQ-1:0]           pt_ready,
  output logic [N_REQ-1:0]           grant,
  output logic [DAC_WIDTH-1:0]       xch,
  output logic [DAC_WIDTH-1:0]       ych,
  output logic                       trig,
  output logic                       overrun
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int DW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [FW-1:0]        FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [DW-1:0]        SETTLE_LD  = DW'(SETTLE_CYCLES);
  localparam logic [DAC_WIDTH-1:0] PARK_XV    = DAC_WIDTH'(PARK_X);
  localparam logic [DAC_WIDTH-1:0] PARK_YV    = DAC_WIDTH'(PARK_Y);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_STREAM,
    S_PARK
  } state_e;

  state_e               state_q, state_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [N_REQ-1:0]     mask_q, mask_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [DAC_WIDTH-1:0] xch_q, xch_d;
  logic [DAC_WIDTH-1:0] ych_q, ych_d;
  logic                 trig_q, trig_d;
  logic                 overrun_q, overrun_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic                 last_f_q, last_f_d;

  logic                 tick;
  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        pick_next;
  logic [N_REQ-1:0]     pick_oh;
  logic                 ready_c;
  logic                 accept;

  assign tick = (fcnt_q == FRAME_LAST);

  // Cyclic first-set search over the frame mask, starting at the round-robin pointer.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    jj       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!pick_vld && mask_q[jj]) begin
        pick_vld = 1'b1;
        pick_idx = jj;
      end
    end
  end

  assign pick_next = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign pick_oh   = N_REQ'(1) << pick_idx;

  // Owner may present a point only once the beam has settled, and not after its last point.
  assign ready_c  = (state_q == S_STREAM) && (dwell_q == '0) && !last_f_q;
  assign accept   = ready_c && pt_valid[owner_q];
  assign pt_ready = ready_c ? grant_q : '0;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = tick ? '0 : fcnt_q + 1'b1;
    mask_d    = mask_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    xch_d     = xch_q;
    ych_d     = ych_q;
    trig_d    = 1'b0;
    overrun_d = overrun_q | (tick && (state_q != S_IDLE));
    dwell_d   = dwell_q;
    last_f_d  = last_f_q;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          mask_d  = req;
          trig_d  = 1'b1;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (!pick_vld) begin
          state_d = S_PARK;
        end else begin
          grant_d  = pick_oh;
          owner_d  = pick_idx;
          rr_ptr_d = pick_next;
          mask_d   = mask_q & ~pick_oh;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept) begin
          xch_d   = pt_x[owner_q*DAC_WIDTH +: DAC_WIDTH];
          ych_d   = pt_y[owner_q*DAC_WIDTH +: DAC_WIDTH];
          dwell_d = SETTLE_LD;
          if (pt_last[owner_q]) last_f_d = 1'b1;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end
        // Leave as the dwell after the final point expires so ARB lands on dwell==0.
        if (!accept && last_f_q && (dwell_q <= DW'(1))) begin
          last_f_d = 1'b0;
          grant_d  = '0;
          dwell_d  = '0;
          state_d  = S_ARB;
        end
      end
      S_PARK: begin
        xch_d   = PARK_XV;
        ych_d   = PARK_YV;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      mask_q    <= '0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      xch_q     <= PARK_XV;
      ych_q     <= PARK_YV;
      trig_q    <= 1'b0;
      overrun_q <= 1'b0;
      dwell_q   <= '0;
      last_f_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      mask_q    <= mask_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      xch_q     <= xch_d;
      ych_q     <= ych_d;
      trig_q    <= trig_d;
      overrun_q <= overrun_d;
      dwell_q   <= dwell_d;
      last_f_q  <= last_f_d;
    end
  end

  assign grant   = grant_q;
  assign xch     = xch_q;
  assign ych     = ych_q;
  assign trig    = trig_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_dac_frame_sched.sv
// Bench for dac_frame_sched: frame-level vector table plus hand-written reset sequences,
// with a small point-stream responder driving the ready/valid handshake.
module tb_dac_frame_sched;

  localparam int N = 4;
  localparam int W = 8;
  localparam int F = 64;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] pt_x = '0;
  logic [N*W-1:0] pt_y = '0;
  logic [N-1:0]   pt_valid = '0;
  logic [N-1:0]   pt_last = '0;
  logic [N-1:0]   pt_ready;
  logic [N-1:0]   grant;
  logic [W-1:0]   xch;
  logic [W-1:0]   ych;
  logic           trig;
  logic           overrun;

  dac_frame_sched #(
    .N_REQ(N), .DAC_WIDTH(W), .FRAME_CYCLES(F), .SETTLE_CYCLES(S),
    .PARK_X(128), .PARK_Y(128)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .pt_x(pt_x), .pt_y(pt_y),
    .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
    .grant(grant), .xch(xch), .ych(ych), .trig(trig), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       req;
    logic [3:0][7:0]  npts;
    int               gap;
    int               ng;
    logic [3:0][1:0]  order;
    int               nacc;
    int               sp;
    logic             ovr;
    int               run;
    int               t2;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int npts[N];
  int idx[N];
  int wait_c[N];
  int gap = 0;
  int xerr = 0;
  int herr = 0;
  int acc_cyc[$];
  int grant_log[$];
  int trig_log[$];

  function automatic logic [7:0] px(int i, int k);
    return 8'(10 + 20*k + 64*i);
  endfunction

  function automatic logic [7:0] py(int i, int k);
    return 8'(20 + 20*k + 64*i);
  endfunction

  function automatic vec_t mk(logic [3:0] r, int n0, int n1, int n2, int n3, int g,
                              int ng, int o0, int o1, int o2, int nacc, int sp,
                              logic ovr, int run, int t2);
    vec_t v;
    v.req = r;
    v.npts[0] = 8'(n0); v.npts[1] = 8'(n1); v.npts[2] = 8'(n2); v.npts[3] = 8'(n3);
    v.gap = g; v.ng = ng;
    v.order[0] = 2'(o0); v.order[1] = 2'(o1); v.order[2] = 2'(o2); v.order[3] = 2'd0;
    v.nacc = nacc; v.sp = sp; v.ovr = ovr; v.run = run; v.t2 = t2;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (idx[i] < npts[i] && wait_c[i] == 0) begin
        pt_valid[i]       = 1'b1;
        pt_x[i*W +: W]    = px(i, idx[i]);
        pt_y[i*W +: W]    = py(i, idx[i]);
        pt_last[i]        = (idx[i] == npts[i] - 1);
      end else begin
        pt_valid[i] = 1'b0;
        pt_last[i]  = 1'b0;
        if (wait_c[i] > 0) wait_c[i]--;
      end
    end
  endtask

  task automatic load(input logic [3:0] r, input int n0, input int n1, input int n2,
                      input int n3, input int g);
    npts[0] = n0; npts[1] = n1; npts[2] = n2; npts[3] = n3;
    gap = g;
    for (int i = 0; i < N; i++) begin
      idx[i] = 0;
      wait_c[i] = g;
    end
    req = r;
    drive();
  endtask

  task automatic step();
    logic [N-1:0] acc;
    logic [N-1:0] gprev;
    logic [W-1:0] xprev;
    logic         rprev;
    int           a;
    acc   = rst ? '0 : (pt_valid & pt_ready);
    gprev = grant;
    xprev = xch;
    rprev = rst;
    @(posedge clk);
    #1;
    cyc++;
    a = -1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] === 1'b1) a = i;
    end
    if (a >= 0) begin
      acc_cyc.push_back(cyc - 1);
      if (xch !== px(a, idx[a]) || ych !== py(a, idx[a])) xerr++;
      idx[a]++;
      wait_c[a] = gap;
    end else if (!rprev && gprev != '0 && xch !== xprev) begin
      herr++;
    end
    if (trig === 1'b1) trig_log.push_back(cyc);
    if (grant != '0 && gprev == '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
    end
    drive();
  endtask

  vec_t vecs[6];

  initial begin
    int rel;
    int bad_x;
    int bad_g;
    int t0;
    int n;
    int mn;
    int mx;
    int d;

    vecs[0] = mk(4'b1011, 1, 1, 0, 1, 0, 3, 0, 1, 3, 3, 6, 1'b0, 50, -1);
    vecs[1] = mk(4'b1011, 1, 1, 0, 1, 0, 3, 0, 1, 3, 3, 6, 1'b0, 50, -1);
    vecs[2] = mk(4'b0001, 3, 0, 0, 0, 0, 1, 0, 0, 0, 3, 5, 1'b0, 50, -1);
    vecs[3] = mk(4'b0010, 0, 3, 0, 0, 5, 1, 1, 0, 0, 3, 6, 1'b0, 50, -1);
    vecs[4] = mk(4'b0110, 0, 1, 1, 0, 0, 2, 2, 1, 0, 2, 6, 1'b0, 50, -1);
    vecs[5] = mk(4'b0001, 20, 0, 0, 0, 0, 1, 0, 0, 0, 20, 5, 1'b1, 2*F + 6, 2*F);

    load(4'b0000, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) step();
    chk("reset xch", int'(xch), 128);
    chk("reset ych", int'(ych), 128);
    chk("reset trig", int'(trig), 0);
    chk("reset grant", int'(grant), 0);
    chk("reset pt_ready", int'(pt_ready), 0);
    chk("reset overrun", int'(overrun), 0);

    // Idle frames: trigger cadence with no requesters, beam stays parked.
    rst = 1'b0;
    rel = cyc;
    trig_log.delete();
    grant_log.delete();
    bad_x = 0;
    bad_g = 0;
    for (int k = 0; k < 2*F + 2; k++) begin
      step();
      if (xch !== 8'd128 || ych !== 8'd128) bad_x++;
      if (grant != '0) bad_g++;
    end
    chk("idle first trig", (trig_log.size() > 0) ? trig_log[0] - rel : -1, F);
    chk("idle second trig", (trig_log.size() > 1) ? trig_log[1] - rel : -1, 2*F);
    chk("idle trig count", trig_log.size(), 2);
    chk("idle xch parked", bad_x, 0);
    chk("idle grant", bad_g, 0);

    for (int v = 0; v < 6; v++) begin
      acc_cyc.delete();
      grant_log.delete();
      xerr = 0;
      herr = 0;
      load(vecs[v].req, int'(vecs[v].npts[0]), int'(vecs[v].npts[1]),
           int'(vecs[v].npts[2]), int'(vecs[v].npts[3]), vecs[v].gap);
      n = 0;
      while (trig !== 1'b1 && n < 2*F + 4) begin
        step();
        n++;
      end
      chk($sformatf("v%0d trig seen", v), int'(trig === 1'b1), 1);
      t0 = cyc;
      trig_log.delete();
      req = 4'b0000;
      repeat (vecs[v].run) step();

      chk($sformatf("v%0d grant count", v), grant_log.size(), vecs[v].ng);
      for (int j = 0; j < vecs[v].ng; j++)
        chk($sformatf("v%0d grant order %0d", v, j),
            (j < grant_log.size()) ? grant_log[j] : -1, int'(vecs[v].order[j]));
      chk($sformatf("v%0d accepts", v), acc_cyc.size(), vecs[v].nacc);
      chk($sformatf("v%0d first accept latency", v),
          (acc_cyc.size() > 0) ? acc_cyc[0] - t0 : -1, 1);
      mn = -1;
      mx = -1;
      for (int j = 1; j < acc_cyc.size(); j++) begin
        d = acc_cyc[j] - acc_cyc[j-1];
        if (mn < 0 || d < mn) mn = d;
        if (d > mx) mx = d;
      end
      chk($sformatf("v%0d min accept spacing", v), mn, vecs[v].sp);
      chk($sformatf("v%0d max accept spacing", v), mx, vecs[v].sp);
      chk($sformatf("v%0d xy after accept errors", v), xerr, 0);
      chk($sformatf("v%0d xy hold errors", v), herr, 0);
      chk($sformatf("v%0d overrun", v), int'(overrun), int'(vecs[v].ovr));
      chk($sformatf("v%0d end xch", v), int'(xch), 128);
      chk($sformatf("v%0d end ych", v), int'(ych), 128);
      chk($sformatf("v%0d end grant", v), int'(grant), 0);
      if (vecs[v].t2 >= 0)
        chk($sformatf("v%0d next trig", v),
            (trig_log.size() > 0) ? trig_log[0] - t0 : -1, vecs[v].t2);
      else
        chk($sformatf("v%0d stray trig", v), trig_log.size(), 0);
    end

    // Reset in the middle of a stream: everything back to idle, frame timing restarts.
    load(4'b0001, 10, 0, 0, 0, 0);
    n = 0;
    while (trig !== 1'b1 && n < 2*F + 4) begin
      step();
      n++;
    end
    chk("rst-seq trig seen", int'(trig === 1'b1), 1);
    repeat (3) step();
    chk("rst-seq streaming grant", int'(grant), 1);
    rst = 1'b1;
    step();
    chk("rst-seq grant", int'(grant), 0);
    chk("rst-seq pt_ready", int'(pt_ready), 0);
    chk("rst-seq trig", int'(trig), 0);
    chk("rst-seq xch", int'(xch), 128);
    chk("rst-seq ych", int'(ych), 128);
    chk("rst-seq overrun cleared", int'(overrun), 0);
    rst = 1'b0;
    rel = cyc;
    trig_log.delete();
    repeat (F + 2) step();
    chk("rst-seq restart trig", (trig_log.size() > 0) ? trig_log[0] - rel : -1, F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
